add_tree_reduce_seq: RTL and testbench

ADD_TREE_REDUCE_SEQ -- requirements
Module: add_tree_reduce_seq

---
 rtl/add_tree_reduce_seq.sv | 67 ++++++
 tb/tb_add_tree_reduce_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/add_tree_reduce_seq.sv
// Sequential adder-tree reduction: sums N_IN unsigned operands by folding the
// accumulator array in half once per cycle, then holds the result until consumed.
module add_tree_reduce_seq #(
  parameter int N_IN = 32,
  parameter int IN_W = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_IN*IN_W-1:0]         in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IN_W+$clog2(N_IN)-1:0] out_sum,
  output logic                         busy
);

  localparam int LOG2N = $clog2(N_IN);
  localparam int OUT_W = IN_W + LOG2N;
  localparam int LVL_W = $clog2(LOG2N + 1);
  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(LOG2N - 1);

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } state_t;

  state_t           state_q;
  logic [LVL_W-1:0] lvl_q;
  logic [OUT_W-1:0] acc_q [N_IN];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lvl_q   <= '0;
      for (int k = 0; k < N_IN; k++) acc_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < N_IN; k++) acc_q[k] <= OUT_W'(in_data[k*IN_W +: IN_W]);
            lvl_q   <= '0;
            state_q <= REDUCE;
          end
        end
        REDUCE: begin
          // Fold every pair each cycle; entries past the live half are don't-care,
          // and the live ones never exceed OUT_W since the full sum fits.
          for (int i = 0; i < N_IN / 2; i++) acc_q[i] <= acc_q[2*i] + acc_q[2*i+1];
          lvl_q <= lvl_q + LVL_W'(1);
          if (lvl_q == LVL_LAST) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q[0];

endmodule

// File: tb/tb_add_tree_reduce_seq.sv
// Directed and randomised checks of add_tree_reduce_seq at N_IN=32 and N_IN=2.
module tb_add_tree_reduce_seq;

  logic clk = 1'b0;
  logic rst_n;

  logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [191:0] in_data_a;
  logic [10:0]  out_sum_a;

  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [11:0]  in_data_b;
  logic [6:0]   out_sum_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_tree_reduce_seq #(.N_IN(32), .IN_W(6)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_sum(out_sum_a),
    .busy(busy_a)
  );

  add_tree_reduce_seq #(.N_IN(2), .IN_W(6)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_sum(out_sum_b),
    .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [191:0] fill(input logic [5:0] v);
    logic [191:0] d;
    for (int k = 0; k < 32; k++) d[k*6 +: 6] = v;
    return d;
  endfunction

  // Offer one vector on DUT A and hold it until the accept edge.
  task automatic send_a(input logic [191:0] d);
    int n = 0;
    while (!in_ready_a && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready_a) chk("send_timeout", 32'(in_ready_a), 32'd1);
    in_valid_a = 1'b1;
    in_data_a  = d;
    tick();
    in_valid_a = 1'b0;
  endtask

  task automatic wait_valid_a(output int lat);
    lat = 0;
    while (!out_valid_a && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  int           lat;
  int           got;
  logic [191:0] d;
  logic [31:0]  exp_sum;

  initial begin
    rst_n       = 1'b0;
    in_valid_a  = 1'b0;
    in_data_a   = '0;
    out_ready_a = 1'b1;
    in_valid_b  = 1'b0;
    in_data_b   = '0;
    out_ready_b = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready_a), 32'd1);
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_out_sum", 32'(out_sum_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;

    // All operands at max value; accept on first edge after reset release.
    send_a(fill(6'd63));
    chk("max_busy", 32'(busy_a), 32'd1);
    chk("max_in_ready_low", 32'(in_ready_a), 32'd0);
    wait_valid_a(lat);
    chk("max_latency", 32'(lat), 32'd5);
    chk("max_sum", 32'(out_sum_a), 32'd2016);
    tick();
    chk("max_back_idle_valid", 32'(out_valid_a), 32'd0);
    chk("max_back_idle_ready", 32'(in_ready_a), 32'd1);

    // Ramp 0..31, then zeros back to back.
    for (int k = 0; k < 32; k++) d[k*6 +: 6] = 6'(k);
    send_a(d);
    wait_valid_a(lat);
    chk("ramp_sum", 32'(out_sum_a), 32'd496);
    tick();
    chk("ramp_first_idle", 32'(in_ready_a), 32'd1);
    send_a('0);
    wait_valid_a(lat);
    chk("zero_latency", 32'(lat), 32'd5);
    chk("zero_sum", 32'(out_sum_a), 32'd0);
    tick();

    // Backpressure in DONE with in_valid and in_data churning.
    out_ready_a = 1'b0;
    send_a(fill(6'd63));
    wait_valid_a(lat);
    chk("bp_sum", 32'(out_sum_a), 32'd2016);
    for (int c = 0; c < 3; c++) begin
      in_valid_a = 1'b1;
      for (int k = 0; k < 32; k++) in_data_a[k*6 +: 6] = 6'($urandom_range(0, 63));
      tick();
      chk("bp_hold_sum", 32'(out_sum_a), 32'd2016);
      chk("bp_hold_valid", 32'(out_valid_a), 32'd1);
      chk("bp_in_ready", 32'(in_ready_a), 32'd0);
    end
    out_ready_a = 1'b1;
    tick();
    chk("bp_release_no_accept", 32'(busy_a), 32'd0);
    in_valid_a = 1'b0;

    // Reset mid-REDUCE at lvl=2.
    send_a(fill(6'd63));
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_out_valid", 32'(out_valid_a), 32'd0);
    chk("midrst_in_ready", 32'(in_ready_a), 32'd1);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_out_sum", 32'(out_sum_a), 32'd0);
    send_a(fill(6'd1));
    wait_valid_a(lat);
    chk("ones_latency", 32'(lat), 32'd5);
    chk("ones_sum", 32'(out_sum_a), 32'd32);
    tick();

    // Two-operand instance.
    in_valid_b = 1'b1;
    in_data_b  = {6'd63, 6'd63};
    tick();
    in_valid_b = 1'b0;
    lat = 0;
    while (!out_valid_b && lat < 10) begin
      tick();
      lat++;
    end
    chk("n2_latency", 32'(lat), 32'd1);
    chk("n2_sum", 32'(out_sum_b), 32'd126);
    tick();
    chk("n2_back_idle", 32'(in_ready_b), 32'd1);

    // Random vectors with random consumer stalls against a reference sum.
    for (int t = 0; t < 1000; t++) begin
      exp_sum = '0;
      for (int k = 0; k < 32; k++) begin
        d[k*6 +: 6] = 6'($urandom_range(0, 63));
        exp_sum += 32'(d[k*6 +: 6]);
      end
      if ($urandom_range(0, 3) == 0) tick();
      send_a(d);
      got = 0;
      lat = 0;
      while (got == 0 && lat < 100) begin
        out_ready_a = 1'($urandom_range(0, 1));
        if (out_valid_a && out_ready_a) begin
          chk("rand_sum", 32'(out_sum_a), exp_sum);
          got = 1;
        end
        tick();
        lat++;
      end
      if (got == 0) chk("rand_timeout", 32'(got), 32'd1);
      chk("rand_no_dup", 32'(out_valid_a), 32'd0);
    end
    out_ready_a = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
